// File: rtl/order_pkg.sv
// Shared state encoding and default configuration for the order machine.
package order_pkg;

   localparam int unsigned N_ITEMS_DEF = 4;
   localparam int unsigned QTY_W_DEF   = 4;
   localparam int unsigned PRICE_W_DEF = 10;

   // item3..item0 unit prices, item i at bits [i*PRICE_W +: PRICE_W]
   localparam logic [N_ITEMS_DEF*PRICE_W_DEF-1:0] PRICE_TABLE_DEF =
      {10'd35, 10'd30, 10'd35, 10'd70};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ORDER = 2'd1,
      ST_PAY   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/order_machine_n_if.sv
// Button, coin and status bundle of the order machine; slave side is the machine.
interface order_machine_n_if #(
   parameter int unsigned N_ITEMS = 4,
   parameter int unsigned QTY_W   = 4,
   parameter int unsigned PRICE_W = 10
);
   logic [N_ITEMS-1:0]       btn_item;
   logic                     btn_confirm;
   logic                     btn_cancel;
   logic                     coin_valid;
   logic [PRICE_W-1:0]       coin_value;
   logic [N_ITEMS-1:0]       led_item;
   logic [N_ITEMS*QTY_W-1:0] qty_flat;
   logic [PRICE_W-1:0]       total_price;
   logic [PRICE_W-1:0]       paid;
   logic [PRICE_W-1:0]       change;
   logic                     order_done;
   logic                     ovf_err;
   logic [1:0]               state;

   modport master (
      output btn_item, btn_confirm, btn_cancel, coin_valid, coin_value,
      input  led_item, qty_flat, total_price, paid, change, order_done, ovf_err, state
   );

   modport slave (
      input  btn_item, btn_confirm, btn_cancel, coin_valid, coin_value,
      output led_item, qty_flat, total_price, paid, change, order_done, ovf_err, state
   );
endinterface

// File: rtl/order_item_cnt.sv
// Saturating per-item quantity counter with a registered nonzero flag.
module order_item_cnt #(
   parameter int unsigned QTY_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clear,
   output logic [QTY_W-1:0] qty,
   output logic             at_max,
   output logic             nonzero
);

   logic [QTY_W-1:0] qty_q;
   logic [QTY_W-1:0] qty_nxt;
   logic             nz_q;

   always_comb begin
      qty_nxt = qty_q;
      if (clear)
         qty_nxt = '0;
      else if (inc && !at_max)
         qty_nxt = qty_q + QTY_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         qty_q <= '0;
         nz_q  <= 1'b0;
      end else begin
         qty_q <= qty_nxt;
         nz_q  <= (qty_nxt != '0);
      end
   end

   assign qty     = qty_q;
   assign at_max  = (qty_q == {QTY_W{1'b1}});
   assign nonzero = nz_q;

endmodule

// File: rtl/order_machine_n.sv
// Menu order / payment controller. Optional cancel-with-refund under `ORDER_CANCEL_EN.
module order_machine_n
   import order_pkg::*;
#(
   parameter int unsigned                     N_ITEMS     = N_ITEMS_DEF,
   parameter int unsigned                     QTY_W       = QTY_W_DEF,
   parameter int unsigned                     PRICE_W     = PRICE_W_DEF,
   parameter logic [N_ITEMS*PRICE_W-1:0]      PRICE_TABLE = PRICE_TABLE_DEF
) (
   input logic              clk,
   input logic              reset_n,
   order_machine_n_if.slave bus
);

   // headroom for summing up to 8 prices onto the running total
   localparam int unsigned EXT_W = PRICE_W + 4;
   localparam logic [EXT_W-1:0] MAX_SUM = EXT_W'({PRICE_W{1'b1}});

   state_e             state_q, state_nxt;
   logic [PRICE_W-1:0] total_q, total_nxt;
   logic [PRICE_W-1:0] paid_q, paid_nxt;
   logic [PRICE_W-1:0] change_q, change_nxt;
   logic               done_q, done_nxt;
   logic               ovf_q, ovf_nxt;
   logic               run_q;

   logic [N_ITEMS-1:0]       inc, acc, at_max, nz;
   logic                     clr;
   logic [N_ITEMS*QTY_W-1:0] qty_w;
   logic [EXT_W-1:0]         add_sum;
   logic [PRICE_W:0]         coin_sum;

   // reset release takes effect one edge later, so the second edge is the first active one
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) run_q <= 1'b0;
      else          run_q <= 1'b1;
   end

   for (genvar g = 0; g < N_ITEMS; g++) begin : g_cnt
      order_item_cnt #(.QTY_W(QTY_W)) u_cnt (
         .clk     (clk),
         .reset_n (reset_n),
         .inc     (inc[g]),
         .clear   (clr),
         .qty     (qty_w[g*QTY_W +: QTY_W]),
         .at_max  (at_max[g]),
         .nonzero (nz[g])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         total_q  <= '0;
         paid_q   <= '0;
         change_q <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         total_q  <= total_nxt;
         paid_q   <= paid_nxt;
         change_q <= change_nxt;
         done_q   <= done_nxt;
         ovf_q    <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt  = state_q;
      total_nxt  = total_q;
      paid_nxt   = paid_q;
      change_nxt = change_q;
      done_nxt   = 1'b0;
      ovf_nxt    = 1'b0;
      inc        = '0;
      acc        = '0;
      clr        = 1'b0;
      add_sum    = EXT_W'(total_q);
      coin_sum   = {1'b0, paid_q} + {1'b0, bus.coin_value};

      // all presses of a cycle land together or, on overflow, not at all
      if (state_q == ST_IDLE || state_q == ST_ORDER) begin
         for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (bus.btn_item[i] && !at_max[i]) begin
               acc[i]  = 1'b1;
               add_sum = add_sum + EXT_W'(PRICE_TABLE[i*PRICE_W +: PRICE_W]);
            end
         end
         if (add_sum > MAX_SUM) begin
            ovf_nxt = 1'b1;
         end else begin
            inc       = acc;
            total_nxt = PRICE_W'(add_sum);
         end
      end

      case (state_q)
         ST_IDLE:  if (|inc) state_nxt = ST_ORDER;
         ST_ORDER: if (bus.btn_confirm && total_nxt != '0) state_nxt = ST_PAY;
         ST_PAY: begin
            if (bus.coin_valid) begin
               if (coin_sum[PRICE_W]) ovf_nxt = 1'b1;
               else                   paid_nxt = coin_sum[PRICE_W-1:0];
            end
            // a coin landing in the completion cycle still counts toward change
            if (paid_q >= total_q) begin
               state_nxt  = ST_DONE;
               change_nxt = paid_nxt - total_q;
               done_nxt   = 1'b1;
               clr        = 1'b1;
               total_nxt  = '0;
               paid_nxt   = '0;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase

`ifdef ORDER_CANCEL_EN
      if (bus.btn_cancel && (state_q == ST_ORDER || state_q == ST_PAY)) begin
         state_nxt  = ST_IDLE;
         inc        = '0;
         clr        = 1'b1;
         total_nxt  = '0;
         paid_nxt   = '0;
         change_nxt = paid_q;
         done_nxt   = 1'b0;
         ovf_nxt    = 1'b0;
      end
`endif

      if (!run_q) begin
         state_nxt  = state_q;
         total_nxt  = total_q;
         paid_nxt   = paid_q;
         change_nxt = change_q;
         done_nxt   = 1'b0;
         ovf_nxt    = 1'b0;
         inc        = '0;
         clr        = 1'b0;
      end
   end

`ifndef ORDER_CANCEL_EN
   logic unused_cancel;
   assign unused_cancel = bus.btn_cancel;
`endif

   assign bus.led_item    = nz;
   assign bus.qty_flat    = qty_w;
   assign bus.total_price = total_q;
   assign bus.paid        = paid_q;
   assign bus.change      = change_q;
   assign bus.order_done  = done_q;
   assign bus.ovf_err     = ovf_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_order_machine_n.sv
// Directed self-checking bench for order_machine_n at default parameters.
module tb_order_machine_n;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   order_machine_n_if #(.N_ITEMS(4), .QTY_W(4), .PRICE_W(10)) bus ();

   order_machine_n dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // drive one cycle of inputs, sample 1 time unit after the edge, then idle inputs
   task automatic cyc(input logic [3:0] items, input logic confirm, input logic cancel,
                      input logic cv, input logic [9:0] cval);
      bus.btn_item    = items;
      bus.btn_confirm = confirm;
      bus.btn_cancel  = cancel;
      bus.coin_valid  = cv;
      bus.coin_value  = cval;
      @(posedge clk);
      #1;
      bus.btn_item    = '0;
      bus.btn_confirm = 1'b0;
      bus.btn_cancel  = 1'b0;
      bus.coin_valid  = 1'b0;
      bus.coin_value  = '0;
   endtask

   task automatic check_cleared(input string tag);
      check_eq({tag, "_state"}, 32'(bus.state), 0);
      check_eq({tag, "_qty"},   32'(bus.qty_flat), 0);
      check_eq({tag, "_led"},   32'(bus.led_item), 0);
      check_eq({tag, "_total"}, 32'(bus.total_price), 0);
      check_eq({tag, "_paid"},  32'(bus.paid), 0);
      check_eq({tag, "_chg"},   32'(bus.change), 0);
      check_eq({tag, "_done"},  32'(bus.order_done), 0);
      check_eq({tag, "_ovf"},   32'(bus.ovf_err), 0);
   endtask

   initial begin
      int ovf_seen;
      bus.btn_item    = '0;
      bus.btn_confirm = 1'b0;
      bus.btn_cancel  = 1'b0;
      bus.coin_valid  = 1'b0;
      bus.coin_value  = '0;

      #3;
      check_cleared("rst");
      #19;
      reset_n = 1'b1;

      // first edge after release is not yet active
      cyc(4'b0001, 1'b0, 1'b0, 1'b0, 10'd0);
      check_eq("sync_qty", 32'(bus.qty_flat), 0);
      check_eq("sync_state", 32'(bus.state), 0);

      // two items in one cycle: 70 + 35
      cyc(4'b0011, 1'b0, 1'b0, 1'b0, 10'd0);
      check_eq("add2_qty", 32'(bus.qty_flat), 32'h0011);
      check_eq("add2_led", 32'(bus.led_item), 32'b0011);
      check_eq("add2_total", 32'(bus.total_price), 105);
      check_eq("add2_state", 32'(bus.state), 1);

      cyc(4'b0000, 1'b1, 1'b0, 1'b0, 10'd0);
      check_eq("conf_state", 32'(bus.state), 2);
      cyc(4'b0000, 1'b0, 1'b0, 1'b1, 10'd50);
      check_eq("coin1_paid", 32'(bus.paid), 50);
      cyc(4'b0000, 1'b0, 1'b0, 1'b1, 10'd50);
      check_eq("coin2_paid", 32'(bus.paid), 100);
      check_eq("coin2_state", 32'(bus.state), 2);
      cyc(4'b0000, 1'b0, 1'b0, 1'b1, 10'd10);
      check_eq("coin3_paid", 32'(bus.paid), 110);
      check_eq("coin3_done", 32'(bus.order_done), 0);
      cyc(4'b0000, 1'b0, 1'b0, 1'b0, 10'd0);
      check_eq("done_state", 32'(bus.state), 3);
      check_eq("done_pulse", 32'(bus.order_done), 1);
      check_eq("done_change", 32'(bus.change), 5);
      check_eq("done_qty", 32'(bus.qty_flat), 0);
      check_eq("done_led", 32'(bus.led_item), 0);
      check_eq("done_total", 32'(bus.total_price), 0);
      check_eq("done_paid", 32'(bus.paid), 0);
      cyc(4'b0000, 1'b0, 1'b0, 1'b0, 10'd0);
      check_eq("post_state", 32'(bus.state), 0);
      check_eq("post_done", 32'(bus.order_done), 0);
      check_eq("post_change", 32'(bus.change), 5);

      cyc(4'b0000, 1'b1, 1'b0, 1'b0, 10'd0);
      check_eq("idle_conf_state", 32'(bus.state), 0);

      // 14 x 70 = 980; a 15th press would reach 1050
      ovf_seen = 0;
      for (int i = 0; i < 14; i++) begin
         cyc(4'b0001, 1'b0, 1'b0, 1'b0, 10'd0);
         if (bus.ovf_err) ovf_seen++;
      end
      check_eq("fill_ovf", 32'(ovf_seen), 0);
      check_eq("fill_total", 32'(bus.total_price), 980);
      cyc(4'b0001, 1'b0, 1'b0, 1'b0, 10'd0);
      check_eq("ovf_pulse", 32'(bus.ovf_err), 1);
      check_eq("ovf_total", 32'(bus.total_price), 980);
      check_eq("ovf_qty", 32'(bus.qty_flat), 32'h000E);
      cyc(4'b0000, 1'b0, 1'b0, 1'b0, 10'd0);
      check_eq("ovf_clear", 32'(bus.ovf_err), 0);

      // coin overflow on the completion cycle is dropped; change from 1000
      cyc(4'b0000, 1'b1, 1'b0, 1'b0, 10'd0);
      cyc(4'b0000, 1'b0, 1'b0, 1'b1, 10'd1000);
      check_eq("big_paid", 32'(bus.paid), 1000);
      cyc(4'b0000, 1'b0, 1'b0, 1'b1, 10'd30);
      check_eq("coin_ovf", 32'(bus.ovf_err), 1);
      check_eq("big_done", 32'(bus.order_done), 1);
      check_eq("big_change", 32'(bus.change), 20);
      cyc(4'b0000, 1'b0, 1'b0, 1'b0, 10'd0);
      check_eq("big_idle", 32'(bus.state), 0);

      // item2 saturates at 15: 15 x 30 = 450
      ovf_seen = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(4'b0100, 1'b0, 1'b0, 1'b0, 10'd0);
         if (bus.ovf_err) ovf_seen++;
      end
      check_eq("sat_ovf", 32'(ovf_seen), 0);
      check_eq("sat_qty", 32'(bus.qty_flat), 32'h0F00);
      check_eq("sat_total", 32'(bus.total_price), 450);
      check_eq("sat_led", 32'(bus.led_item), 32'b0100);

      // item plus confirm together: add first, then confirm
      cyc(4'b1000, 1'b1, 1'b0, 1'b0, 10'd0);
      check_eq("addconf_total", 32'(bus.total_price), 485);
      check_eq("addconf_state", 32'(bus.state), 2);
      check_eq("addconf_qty", 32'(bus.qty_flat), 32'h1F00);
      cyc(4'b0001, 1'b0, 1'b0, 1'b0, 10'd0);
      check_eq("pay_item_total", 32'(bus.total_price), 485);
      check_eq("pay_item_qty", 32'(bus.qty_flat), 32'h1F00);
      cyc(4'b0000, 1'b0, 1'b0, 1'b1, 10'd50);
      check_eq("mid_paid", 32'(bus.paid), 50);

      // asynchronous reset between edges
      #2;
      reset_n = 1'b0;
      #1;
      check_cleared("async");
      @(negedge clk);
      reset_n = 1'b1;
      cyc(4'b0000, 1'b0, 1'b0, 1'b0, 10'd0);

      cyc(4'b0001, 1'b0, 1'b0, 1'b0, 10'd0);
      check_eq("c_total", 32'(bus.total_price), 70);
      cyc(4'b0000, 1'b1, 1'b0, 1'b0, 10'd0);
      cyc(4'b0000, 1'b0, 1'b0, 1'b1, 10'd20);
      check_eq("c_paid", 32'(bus.paid), 20);
      cyc(4'b0000, 1'b0, 1'b1, 1'b0, 10'd0);
`ifdef ORDER_CANCEL_EN
      check_eq("cancel_state", 32'(bus.state), 0);
      check_eq("cancel_change", 32'(bus.change), 20);
      check_eq("cancel_done", 32'(bus.order_done), 0);
      check_eq("cancel_paid", 32'(bus.paid), 0);
      check_eq("cancel_total", 32'(bus.total_price), 0);
      check_eq("cancel_qty", 32'(bus.qty_flat), 0);
`else
      check_eq("nocancel_state", 32'(bus.state), 2);
      check_eq("nocancel_paid", 32'(bus.paid), 20);
      check_eq("nocancel_change", 32'(bus.change), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
